xalu_ise_pipe: RTL and testbench

- Parametrised, pipelined successor of the reduced-radix CSIDH ISE unit for the RV64 core.
- Executes the reduced-radix ops sraiadd, madd_lo and madd_hi behind a valid/ready handshake with a fixed, configurable latency.
- Supports a third source operand, in-order completion with tag pass-through, back-pressure, and flush.
- Sits between the core's custom-opcode decode/issue stage and the writeback arbiter.

---
 rtl/xalu_ise_pipe_if.sv | 33 +++
 rtl/xalu_ise_pipe.sv | 125 ++++++++++++
 tb/tb_xalu_ise_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/xalu_ise_pipe_if.sv
// Issue/writeback bundle between the core's custom-opcode issue stage and the
// reduced-radix ISE pipe. The master side is the core, the slave side is the unit.
interface xalu_ise_pipe_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  logic [5:0]       ise_fn;
  logic [6:0]       ise_imm;
  logic [XLEN-1:0]  ise_in1;
  logic [XLEN-1:0]  ise_in2;
  logic [XLEN-1:0]  ise_in3;
  logic [TAG_W-1:0] ise_tag;
  logic             ise_val;
  logic             ise_rdy;
  logic             ise_flush;
  logic             ise_oval;
  logic             ise_ordy;
  logic [XLEN-1:0]  ise_out;
  logic [TAG_W-1:0] ise_otag;
  logic             ise_oill;

  modport master (
    output ise_fn, ise_imm, ise_in1, ise_in2, ise_in3, ise_tag, ise_val,
           ise_flush, ise_ordy,
    input  ise_rdy, ise_oval, ise_out, ise_otag, ise_oill
  );

  modport slave (
    input  ise_fn, ise_imm, ise_in1, ise_in2, ise_in3, ise_tag, ise_val,
           ise_flush, ise_ordy,
    output ise_rdy, ise_oval, ise_out, ise_otag, ise_oill
  );
endinterface

// File: rtl/xalu_ise_pipe.sv
// Pipelined reduced-radix ISE unit: sraiadd, madd_lo, madd_hi with fixed latency,
// in-order completion, tag pass-through, back-pressure and flush.
module xalu_ise_pipe #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RADIX   = 57,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned TAG_W   = 5,
  parameter logic [3:0]  ISE_V   = 4'b1010
) (
  input logic            ise_clk,
  input logic            ise_rst,
  xalu_ise_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ILL,
    OP_SRAIADD,
    OP_MADD_LO,
    OP_MADD_HI
  } op_e;

  localparam logic [XLEN-1:0] LO_MASK = {XLEN{1'b1}} >> (XLEN - RADIX);
  localparam logic [5:0]      SH_MASK = (XLEN == 32) ? 6'h1f : 6'h3f;

  logic stall;
  logic accept;
  op_e  dec_op;

  assign stall       = bus.ise_oval && !bus.ise_ordy;
  assign bus.ise_rdy = !stall;
  assign accept      = bus.ise_val && !stall && !bus.ise_flush;

  always_comb begin
    dec_op = OP_ILL;
    if (bus.ise_fn[1:0] == 2'b01 && bus.ise_imm[6] && ISE_V[1])
      dec_op = OP_SRAIADD;
    else if (bus.ise_fn[1:0] == 2'b10 && bus.ise_imm[6:4] == 3'b000 && ISE_V[3])
      dec_op = OP_MADD_LO;
    else if (bus.ise_fn[1:0] == 2'b10 && bus.ise_imm[6:4] == 3'b001 && ISE_V[3])
      dec_op = OP_MADD_HI;
  end

  logic unused_fn;
  assign unused_fn = ^{bus.ise_fn[5:2], ISE_V[2], ISE_V[0]};

  // Operand stage captures the accepted request; the LATENCY result stages
  // behind it make the result visible exactly LATENCY edges after acceptance.
  logic             op_v;
  op_e              op_q;
  logic [TAG_W-1:0] op_tag;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [XLEN-1:0]  op_c;
  logic [5:0]       op_sh;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   sra;
  logic [XLEN-1:0]   res;
  logic              ill;

  always_comb begin
    prod = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};
    sra  = $signed(op_b) >>> op_sh;
    ill  = (op_q == OP_ILL);
    res  = '0;
    case (op_q)
      OP_SRAIADD: res = op_a + sra;
      OP_MADD_LO: res = (prod[XLEN-1:0] & LO_MASK) + op_c;
      OP_MADD_HI: res = XLEN'(prod >> RADIX) + op_c;
      default:    res = '0;
    endcase
  end

  logic [LATENCY-1:0] rs_v;
  logic [LATENCY-1:0] rs_ill;
  logic [TAG_W-1:0]   rs_tag [LATENCY];
  logic [XLEN-1:0]    rs_dat [LATENCY];

  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      op_v   <= 1'b0;
      op_q   <= OP_ILL;
      op_tag <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_c   <= '0;
      op_sh  <= '0;
      rs_v   <= '0;
      rs_ill <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        rs_tag[i] <= '0;
        rs_dat[i] <= '0;
      end
    end else if (bus.ise_flush) begin
      op_v <= 1'b0;
      rs_v <= '0;
    end else if (!stall) begin
      op_v <= accept;
      if (accept) begin
        op_q   <= dec_op;
        op_tag <= bus.ise_tag;
        op_a   <= bus.ise_in1;
        op_b   <= bus.ise_in2;
        op_c   <= bus.ise_in3;
        op_sh  <= bus.ise_imm[5:0] & SH_MASK;
      end
      rs_v[0]   <= op_v;
      rs_ill[0] <= ill;
      rs_tag[0] <= op_tag;
      rs_dat[0] <= res;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        rs_v[i]   <= rs_v[i-1];
        rs_ill[i] <= rs_ill[i-1];
        rs_tag[i] <= rs_tag[i-1];
        rs_dat[i] <= rs_dat[i-1];
      end
    end
  end

  assign bus.ise_oval = rs_v[LATENCY-1];
  assign bus.ise_oill = rs_ill[LATENCY-1];
  assign bus.ise_otag = rs_tag[LATENCY-1];
  assign bus.ise_out  = rs_dat[LATENCY-1];

endmodule

// File: tb/tb_xalu_ise_pipe.sv
// Directed bench for xalu_ise_pipe: default 64-bit/LATENCY=3 instance plus a
// 32-bit/RADIX=28/LATENCY=1 instance sharing clock and reset.
module tb_xalu_ise_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xalu_ise_pipe_if #(.XLEN(64), .TAG_W(5)) bus ();
  xalu_ise_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();

  xalu_ise_pipe #(
    .XLEN(64), .RADIX(57), .LATENCY(3), .TAG_W(5), .ISE_V(4'b1010)
  ) dut (
    .ise_clk(clk),
    .ise_rst(rst),
    .bus    (bus)
  );

  xalu_ise_pipe #(
    .XLEN(32), .RADIX(28), .LATENCY(1), .TAG_W(5), .ISE_V(4'b1010)
  ) dut32 (
    .ise_clk(clk),
    .ise_rst(rst),
    .bus    (bus32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] fn, input logic [6:0] imm,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [4:0] tag);
    bus.ise_fn  = fn;
    bus.ise_imm = imm;
    bus.ise_in1 = a;
    bus.ise_in2 = b;
    bus.ise_in3 = c;
    bus.ise_tag = tag;
    bus.ise_val = 1'b1;
  endtask

  task automatic idle();
    bus.ise_val = 1'b0;
  endtask

  int next;

  initial begin
    bus.ise_fn = '0; bus.ise_imm = '0; bus.ise_in1 = '0; bus.ise_in2 = '0;
    bus.ise_in3 = '0; bus.ise_tag = '0; bus.ise_val = 1'b0;
    bus.ise_flush = 1'b0; bus.ise_ordy = 1'b1;
    bus32.ise_fn = '0; bus32.ise_imm = '0; bus32.ise_in1 = '0; bus32.ise_in2 = '0;
    bus32.ise_in3 = '0; bus32.ise_tag = '0; bus32.ise_val = 1'b0;
    bus32.ise_flush = 1'b0; bus32.ise_ordy = 1'b1;
    rst = 1'b1;

    // Reset state
    #12;
    chk("rst_rdy",  64'(bus.ise_rdy),  64'd1);
    chk("rst_oval", 64'(bus.ise_oval), 64'd0);
    chk("rst_out",  bus.ise_out,       64'd0);
    chk("rst_otag", 64'(bus.ise_otag), 64'd0);
    chk("rst_oill", 64'(bus.ise_oill), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // sraiadd: 0x10 + (0xFF..FF00 >>> 4) = 0
    drive(6'b000001, 7'b1000100, 64'h10, 64'hFFFF_FFFF_FFFF_FF00, 64'h0, 5'd3);
    step();
    idle();
    step();
    step();
    chk("srai_early", 64'(bus.ise_oval), 64'd0);
    step();
    chk("srai_oval", 64'(bus.ise_oval), 64'd1);
    chk("srai_out",  bus.ise_out,       64'd0);
    chk("srai_otag", 64'(bus.ise_otag), 64'd3);
    chk("srai_oill", 64'(bus.ise_oill), 64'd0);
    step();
    chk("srai_retired", 64'(bus.ise_oval), 64'd0);

    // madd_lo then madd_hi back-to-back, 2^56 * 4 = 2^58
    drive(6'b000010, 7'b0000000, 64'h0100_0000_0000_0000, 64'd4, 64'd1, 5'd1);
    step();
    drive(6'b000010, 7'b0010000, 64'h0100_0000_0000_0000, 64'd4, 64'd1, 5'd2);
    step();
    idle();
    step();
    step();
    chk("mlo_oval", 64'(bus.ise_oval), 64'd1);
    chk("mlo_out",  bus.ise_out,       64'd1);
    chk("mlo_otag", 64'(bus.ise_otag), 64'd1);
    step();
    chk("mhi_oval", 64'(bus.ise_oval), 64'd1);
    chk("mhi_out",  bus.ise_out,       64'd3);
    chk("mhi_otag", 64'(bus.ise_otag), 64'd2);
    step();
    chk("madd_done", 64'(bus.ise_oval), 64'd0);

    // Back-pressure: tags 0..4, sraiadd shamt=0 gives (100+i)+i
    for (int i = 0; i < 4; i++) begin
      drive(6'b000001, 7'b1000000, 64'(100 + i), 64'(i), 64'd0, 5'(i));
      step();
    end
    chk("bp_first_oval", 64'(bus.ise_oval), 64'd1);
    chk("bp_first_tag",  64'(bus.ise_otag), 64'd0);
    chk("bp_first_out",  bus.ise_out,       64'd100);
    bus.ise_ordy = 1'b0;
    drive(6'b000001, 7'b1000000, 64'd104, 64'd4, 64'd0, 5'd4);
    #1;
    chk("bp_rdy_low", 64'(bus.ise_rdy), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_stall_rdy",  64'(bus.ise_rdy),  64'd0);
      chk("bp_stall_oval", 64'(bus.ise_oval), 64'd1);
      chk("bp_stall_tag",  64'(bus.ise_otag), 64'd0);
      chk("bp_stall_out",  bus.ise_out,       64'd100);
    end
    bus.ise_ordy = 1'b1;
    #1;
    chk("bp_rdy_high", 64'(bus.ise_rdy), 64'd1);
    step();
    idle();
    next = 1;
    for (int c = 0; c < 8; c++) begin
      if (bus.ise_oval) begin
        chk("bp_tag", 64'(bus.ise_otag), 64'(next));
        chk("bp_out", bus.ise_out,       64'(100 + 2 * next));
        next++;
      end
      step();
    end
    chk("bp_count", 64'(next), 64'd5);

    // Flush with a simultaneous request
    drive(6'b000001, 7'b1000000, 64'd1, 64'd1, 64'd0, 5'd10);
    step();
    drive(6'b000001, 7'b1000000, 64'd2, 64'd2, 64'd0, 5'd11);
    step();
    drive(6'b000001, 7'b1000000, 64'd3, 64'd3, 64'd0, 5'd12);
    bus.ise_flush = 1'b1;
    step();
    bus.ise_flush = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) begin
      chk("flush_no_result", 64'(bus.ise_oval), 64'd0);
      step();
    end

    // Illegal ops: fn=11, and fn=10 with an unassigned funct
    drive(6'b000011, 7'b1000000, 64'd5, 64'd6, 64'd7, 5'd7);
    step();
    drive(6'b000010, 7'b0100000, 64'd5, 64'd6, 64'd7, 5'd8);
    step();
    idle();
    step();
    step();
    chk("ill1_oval", 64'(bus.ise_oval), 64'd1);
    chk("ill1_out",  bus.ise_out,       64'd0);
    chk("ill1_oill", 64'(bus.ise_oill), 64'd1);
    chk("ill1_otag", 64'(bus.ise_otag), 64'd7);
    step();
    chk("ill2_out",  bus.ise_out,       64'd0);
    chk("ill2_oill", 64'(bus.ise_oill), 64'd1);
    chk("ill2_otag", 64'(bus.ise_otag), 64'd8);
    step();
    chk("ill_done", 64'(bus.ise_oval), 64'd0);

    // Asynchronous reset with two ops in flight
    drive(6'b000001, 7'b1000000, 64'd1, 64'd1, 64'd0, 5'd20);
    step();
    drive(6'b000001, 7'b1000000, 64'd2, 64'd2, 64'd0, 5'd21);
    step();
    idle();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_oval", 64'(bus.ise_oval), 64'd0);
    chk("arst_out",  bus.ise_out,       64'd0);
    chk("arst_rdy",  64'(bus.ise_rdy),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("arst_no_ghost", 64'(bus.ise_oval), 64'd0);
    end

    // 32-bit variant: madd_hi 2^27 * 2^27 >> 28 = 2^26, plus 5
    bus32.ise_fn  = 6'b000010;
    bus32.ise_imm = 7'b0010000;
    bus32.ise_in1 = 32'h0800_0000;
    bus32.ise_in2 = 32'h0800_0000;
    bus32.ise_in3 = 32'd5;
    bus32.ise_tag = 5'd9;
    bus32.ise_val = 1'b1;
    step();
    bus32.ise_val = 1'b0;
    chk("v32_early", 64'(bus32.ise_oval), 64'd0);
    step();
    chk("v32_oval", 64'(bus32.ise_oval), 64'd1);
    chk("v32_out",  64'(bus32.ise_out),  64'h0400_0005);
    chk("v32_otag", 64'(bus32.ise_otag), 64'd9);
    chk("v32_oill", 64'(bus32.ise_oill), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
